triumph_dmem_ctrl: RTL and testbench
====================================

TRIUMPH_DMEM_CTRL -- requirements
Module: triumph_dmem_ctrl

Interface
REQ-001 Parameter: DEPTH_WORDS, default 256, number of 32-bit RAM words; SHALL be a power of two, 2 to 4096.
REQ-002 Parameter: TICK_DIV, default 50000000, clock cycles per flag1s pulse after reset.
REQ-003 Port: clk_i  input  1  single clock; every register SHALL update on its rising edge.
REQ-004 Port: rst_i  input  1  reset, synchronous and active-high.
REQ-005 Port: dcache_addr_i  input  32  byte address from the core data port.
REQ-006 Port: dcache_write_en_i  input  1  write strobe; a write SHALL occur at the edge where it is 1.
REQ-007 Port: dcache_wdata_i  input  32  write data.
REQ-008 Port: dcache_rdata_o  output  32  read data for dcache_addr_i.
REQ-009 Port: data_display_o  output  32  current DISPLAY register value.
REQ-010 Port: flag1s_o  output  1  one-cycle periodic tick pulse.

Function
REQ-011 Decode: addr[31:16]==16'hFFFF SHALL select MMIO; all other addresses SHALL select RAM.
REQ-012 RAM index SHALL be addr[log2(DEPTH_WORDS)+1:2]; addr[1:0] and upper bits SHALL be ignored, so indices wrap modulo DEPTH_WORDS.
REQ-013 Reads SHALL be combinational, with zero latency: dcache_rdata_o SHALL reflect the addressed location in the same cycle.
REQ-014 For a write and read at the same location in one cycle, dcache_rdata_o SHALL show the old value; the new value SHALL appear from the next cycle.
REQ-015 The MMIO map SHALL be: 0xFFFF0000 DISPLAY (read/write); 0xFFFF0004 TICK_CNT (read-only); 0xFFFF0008 PRESCALE (read/write); 0xFFFF000C STATUS (bit0 TICK_PEND, write-1-to-clear; bits 31:1 read 0).
REQ-016 Unmapped MMIO reads SHALL return 0; writes to unmapped MMIO or to TICK_CNT SHALL have no effect.
REQ-017 data_display_o SHALL equal the DISPLAY register directly, with no extra delay.
REQ-018 Prescaler: a down-counter PCNT SHALL decrement each cycle.
  - When PCNT==0, it SHALL reload with PRESCALE.
  - In that same cycle flag1s_o SHALL be 1; otherwise flag1s_o SHALL be 0.
  - The resulting period SHALL be PRESCALE+1 cycles.
REQ-019 PRESCALE==0 SHALL give flag1s_o held at 1 every cycle.
REQ-020 A write to PRESCALE SHALL load both PRESCALE and PCNT with wdata at that edge, which restarts the period.
REQ-021 On each cycle with flag1s_o=1, TICK_CNT SHALL increment by 1 at the edge, modulo 2^32, so 0xFFFFFFFF wraps to 0.
REQ-022 Each cycle with flag1s_o=1 SHALL set TICK_PEND.
REQ-023 A STATUS write with wdata[0]=1 SHALL clear TICK_PEND.
REQ-024 If a tick and a clearing STATUS write occur in the same cycle, the set SHALL win and TICK_PEND SHALL remain 1.
REQ-025 dcache_write_en_i with an MMIO address SHALL NOT modify RAM, and a RAM address SHALL NOT modify MMIO.

Reset
REQ-026 When rst_i=1 at an edge, the block SHALL set: DISPLAY=0, TICK_CNT=0, TICK_PEND=0, PRESCALE=TICK_DIV-1, PCNT=TICK_DIV-1.
REQ-027 While rst_i=1, flag1s_o SHALL be 0 and writes SHALL be ignored.
REQ-028 RAM contents SHALL NOT be cleared by reset.
REQ-029 Reset asserted mid-period SHALL discard the partial count; the first tick after release SHALL come TICK_DIV cycles after release.
REQ-030 dcache_rdata_o SHALL remain combinational during reset, with no forced value.

Verification
REQ-031 RAM access, DEPTH_WORDS=256:
  - Write 0xDEADBEEF to 0x00000010, then read 0x00000010 -> 0xDEADBEEF.
  - Read 0x00000410 (alias) -> 0xDEADBEEF.
  - Read 0x00000013 -> 0xDEADBEEF.
REQ-032 Same-cycle write/read:
  - Word 4 holds 0x1; write 0x2 to 0x10 while reading 0x10 -> 0x1 that cycle.
  - The following cycle -> 0x2.
REQ-033 Tick timing, TICK_DIV=4:
  - After reset release, flag1s_o pulses on cycles 4, 8, 12 for exactly 1 cycle each.
  - TICK_CNT reads 3 after the third pulse.
  - Write PRESCALE=1 -> pulses every 2 cycles.
  - Write PRESCALE=0 -> flag1s_o constant 1.
REQ-034 STATUS handling:
  - After a tick, STATUS reads 0x1; write 0x1 -> reads 0x0.
  - A clearing write in the same cycle as a tick -> reads 0x1.
REQ-035 MMIO:
  - Write 0x12345678 to 0xFFFF0000 -> data_display_o=0x12345678 next cycle, and RAM word 0 unchanged.
  - Write to 0xFFFF0004 -> TICK_CNT unchanged.
  - Read 0xFFFF0020 -> 0.
REQ-036 Mid-operation reset:
  - Assert rst_i 2 cycles into a TICK_DIV=4 period -> DISPLAY=0, TICK_CNT=0, next pulse 4 cycles after release.
  - RAM word written before reset still reads back its value.

Source files
------------

// File: rtl/triumph_dmem_ctrl.sv
// triumph_dmem_ctrl: single-cycle data RAM with MMIO display, tick prescaler and status registers
module triumph_dmem_ctrl #(
    parameter int DEPTH_WORDS = 256,
    parameter int TICK_DIV    = 50000000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] dcache_addr_i,
    input  logic        dcache_write_en_i,
    input  logic [31:0] dcache_wdata_i,
    output logic [31:0] dcache_rdata_o,
    output logic [31:0] data_display_o,
    output logic        flag1s_o
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [31:0] RST_PRE = 32'(TICK_DIV - 1);
    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] display, tick_cnt, prescale, pcnt, mmio_rdata;
    logic tick_pend, is_mmio, we, sel_disp, sel_cnt, sel_pre, sel_stat;
    logic [AW-1:0] idx;
    assign is_mmio = dcache_addr_i[31:16] == 16'hFFFF;
    assign we = dcache_write_en_i && !rst_i;
    assign sel_disp = is_mmio && dcache_addr_i[15:0] == 16'h0000;
    assign sel_cnt = is_mmio && dcache_addr_i[15:0] == 16'h0004;
    assign sel_pre = is_mmio && dcache_addr_i[15:0] == 16'h0008;
    assign sel_stat = is_mmio && dcache_addr_i[15:0] == 16'h000C;
    assign idx = dcache_addr_i[AW+1:2];
    assign flag1s_o = !rst_i && pcnt == '0;
    assign data_display_o = display;
    always_comb begin
        mmio_rdata = sel_disp ? display :
                     sel_cnt  ? tick_cnt :
                     sel_pre  ? prescale :
                     sel_stat ? {31'b0, tick_pend} : '0;
        dcache_rdata_o = is_mmio ? mmio_rdata : mem[idx];
    end
    // RAM has no reset so its contents survive a reset pulse
    always_ff @(posedge clk_i) begin
        if (we && !is_mmio)
            mem[idx] <= dcache_wdata_i;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            display   <= '0;
            tick_cnt  <= '0;
            tick_pend <= 1'b0;
            prescale  <= RST_PRE;
            pcnt      <= RST_PRE;
        end else begin
            display   <= (we && sel_disp) ? dcache_wdata_i : display;
            prescale  <= (we && sel_pre) ? dcache_wdata_i : prescale;
            pcnt      <= (we && sel_pre) ? dcache_wdata_i : flag1s_o ? prescale : pcnt - 32'd1;
            tick_cnt  <= flag1s_o ? tick_cnt + 32'd1 : tick_cnt;
            // a tick in the same cycle as a clearing write keeps the flag set
            tick_pend <= flag1s_o ? 1'b1 : (we && sel_stat && dcache_wdata_i[0]) ? 1'b0 : tick_pend;
        end
    end
endmodule

// File: tb/tb_triumph_dmem_ctrl.sv
// tb_triumph_dmem_ctrl: directed scoreboard bench for triumph_dmem_ctrl with TICK_DIV=4
module tb_triumph_dmem_ctrl;
    localparam logic [31:0] A_DISP = 32'hFFFF0000;
    localparam logic [31:0] A_CNT  = 32'hFFFF0004;
    localparam logic [31:0] A_PRE  = 32'hFFFF0008;
    localparam logic [31:0] A_STAT = 32'hFFFF000C;
    logic clk = 1'b0;
    logic rst, we, flag;
    logic [31:0] addr, wdata, rdata, disp;
    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    always #5 clk = ~clk;
    triumph_dmem_ctrl #(.DEPTH_WORDS(256), .TICK_DIV(4)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .dcache_addr_i(addr),
        .dcache_write_en_i(we),
        .dcache_wdata_i(wdata),
        .dcache_rdata_o(rdata),
        .data_display_o(disp),
        .flag1s_o(flag)
    );
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, observed %h", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", tag, obs, e);
            end
        end
    endtask
    task automatic chk_flag(input string tag, input logic e);
        exp_q.push_back({31'b0, e});
        chk(tag, {31'b0, flag});
    endtask
    task automatic chk_disp(input string tag, input logic [31:0] e);
        exp_q.push_back(e);
        chk(tag, disp);
    endtask
    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] e);
        we = 1'b0;
        addr = a;
        exp_q.push_back(e);
        #1;
        chk(tag, rdata);
    endtask
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        we = 1'b1;
        addr = a;
        wdata = d;
        tick;
        we = 1'b0;
    endtask
    initial begin
        rst = 1'b1;
        we = 1'b0;
        addr = '0;
        wdata = '0;
        tick;
        tick;
        chk_flag("rst_flag", 1'b0);
        chk_disp("rst_disp", 32'h0);
        rd("rst_cnt", A_CNT, 32'h0);
        rd("rst_stat", A_STAT, 32'h0);
        rd("rst_pre", A_PRE, 32'h3);
        rst = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            chk_flag($sformatf("tick_c%0d", c), (c % 4) == 0);
            tick;
        end
        rd("cnt_after3", A_CNT, 32'h3);
        rd("stat_set", A_STAT, 32'h1);
        wr(A_STAT, 32'h1);
        rd("stat_clr", A_STAT, 32'h0);
        tick;
        tick;
        chk_flag("tick_c16", 1'b1);
        wr(A_STAT, 32'h1);
        rd("stat_set_wins", A_STAT, 32'h1);
        rd("cnt_4", A_CNT, 32'h4);
        wr(32'h0, 32'hCAFEF00D);
        we = 1'b1;
        addr = A_DISP;
        wdata = 32'h12345678;
        #1;
        chk_disp("disp_before_edge", 32'h0);
        tick;
        we = 1'b0;
        chk_disp("disp_after", 32'h12345678);
        rd("disp_rd", A_DISP, 32'h12345678);
        rd("ram0_untouched", 32'h0, 32'hCAFEF00D);
        wr(A_CNT, 32'hFFFFFFFF);
        rd("cnt_ro", A_CNT, 32'h4);
        rd("unmapped", 32'hFFFF0020, 32'h0);
        chk_flag("tick_c20", 1'b1);
        tick;
        wr(32'h10, 32'hDEADBEEF);
        rd("ram_rd", 32'h10, 32'hDEADBEEF);
        rd("ram_alias", 32'h410, 32'hDEADBEEF);
        rd("ram_lowbits", 32'h13, 32'hDEADBEEF);
        wr(32'h10, 32'h1);
        we = 1'b1;
        addr = 32'h10;
        wdata = 32'h2;
        exp_q.push_back(32'h1);
        #1;
        chk("wr_rd_old", rdata);
        tick;
        rd("wr_rd_new", 32'h10, 32'h2);
        rd("ram_upper_ign", 32'hABCD0010, 32'h2);
        chk_flag("tick_c24", 1'b1);
        tick;
        wr(A_PRE, 32'h1);
        rd("pre_rd", A_PRE, 32'h1);
        for (int i = 0; i < 4; i++) begin
            chk_flag($sformatf("pre1_%0d", i), (i % 2) == 1);
            tick;
        end
        chk_flag("pre1_4", 1'b0);
        wr(A_PRE, 32'h0);
        for (int i = 0; i < 5; i++) begin
            chk_flag($sformatf("pre0_%0d", i), 1'b1);
            tick;
        end
        rd("cnt_13", A_CNT, 32'd13);
        wr(A_PRE, 32'h3);
        wr(32'h20, 32'h600DF00D);
        rst = 1'b1;
        we = 1'b1;
        addr = 32'h20;
        wdata = 32'h00000BAD;
        tick;
        we = 1'b0;
        chk_flag("mid_rst_flag", 1'b0);
        chk_disp("mid_rst_disp", 32'h0);
        rd("mid_rst_cnt", A_CNT, 32'h0);
        rd("mid_rst_ram", 32'h20, 32'h600DF00D);
        tick;
        rst = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            chk_flag($sformatf("post_rst_c%0d", c), c == 4);
            tick;
        end
        rd("post_rst_cnt", A_CNT, 32'h1);
        rd("post_rst_ram", 32'h20, 32'h600DF00D);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
